// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared types and constants for the Y86-64 memory stage:
//                responder FSM states, processor status codes, word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Datapath word width of the Y86-64 processor
    localparam int WORD_W = 64;

    // Memory-stage responder states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Processor status codes; an address error from memory becomes ADR
    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_e;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/y86_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : y86_mem_array
//  Description : Byte-wide storage with one 8-byte little-endian combinational
//                read port and one 8-byte synchronous write port with enable.
//                Contents are never cleared; no handshake logic lives here.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_mem_array
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic                clk,
    input  logic                wrEn,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WORD_W-1:0]   wrData,
    output logic [WORD_W-1:0]   rdData
);

    localparam int c_BYTES_PER_WORD = WORD_W / 8;

    logic [7:0] r_mem [MEM_BYTES];

    // Gather 8 consecutive bytes; lowest address lands in the low byte
    always_comb begin
        rdData = '0;
        for (int i = 0; i < c_BYTES_PER_WORD; i++) begin
            rdData[8*i +: 8] = r_mem[addr + ADDR_W'(i)];
        end
    end

    // Scatter the write word across 8 consecutive bytes, little-endian
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < c_BYTES_PER_WORD; i++) begin
                r_mem[addr + ADDR_W'(i)] <= wrData[8*i +: 8];
            end
        end
    end

endmodule : y86_mem_array
`default_nettype wire

// File: rtl/y86_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : y86_data_memory
//  Description : Y86-64 data memory responder for the SEQ memory stage.
//                One 64-bit little-endian read or write per valid/ready
//                request, fixed access latency, out-of-range flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_data_memory
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [WORD_W-1:0]   req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_W-1:0]   rsp_rdata,
    output logic                rsp_error
);

    localparam int c_ADDR_W = $clog2(MEM_BYTES);
    localparam int c_CNT_W  = $clog2(LATENCY) + 1;

    // Highest legal start address: the last full word fits exactly
    localparam logic [WORD_W-1:0] c_MAX_ADDR   = WORD_W'(MEM_BYTES - 8);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(LATENCY - 1);

    mem_state_e             r_state;
    mem_state_e             w_nextState;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_write;
    logic [WORD_W-1:0]      r_addr;
    logic [WORD_W-1:0]      r_wdata;
    logic [WORD_W-1:0]      r_rspRdata;
    logic                   r_rspError;

    logic                   w_accept;
    logic                   w_access;
    logic                   w_err;
    logic                   w_memWrEn;
    logic [WORD_W-1:0]      w_memRdata;

    // Full-width unsigned compare so addresses whose +7 wraps past 2^64
    // are rejected rather than aliasing onto low memory
    assign w_err     = (r_addr > c_MAX_ADDR);
    assign w_memWrEn = w_access & r_write & ~w_err;

    assign rsp_rdata = r_rspRdata;
    assign rsp_error = r_rspError;

    y86_mem_array #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (c_ADDR_W)
    ) u_memArray (
        .clk    (clk),
        .wrEn   (w_memWrEn),
        .addr   (r_addr[c_ADDR_W-1:0]),
        .wrData (r_wdata),
        .rdData (w_memRdata)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs; ready is held low while in reset
    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid && !reset) begin
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_nextState = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rspRdata <= '0;
            r_rspError <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_CNT_LOAD;
            end

            if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_access) begin
                r_rspRdata <= (!w_err && !r_write) ? w_memRdata : '0;
                r_rspError <= w_err;
            end

            if (r_state == RESP && rsp_ready) begin
                r_rspRdata <= '0;
                r_rspError <= 1'b0;
            end
        end
    end

endmodule : y86_data_memory
`default_nettype wire

// File: tb/tb_y86_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y86_data_memory
//  Description : Self-checking bench for y86_data_memory (MEM_BYTES=1024,
//                LATENCY=2): vector table plus hand-written corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_data_memory;

    localparam int c_MEM_BYTES = 1024;
    localparam int c_LATENCY   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    int nCompared = 0;
    int nFailed   = 0;

    y86_data_memory #(
        .MEM_BYTES (c_MEM_BYTES),
        .LATENCY   (c_LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] expRdata;
        bit          expErr;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // One full transaction; lat = cycles from accepting edge to rsp_valid
    task automatic doReq(input bit w, input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] rd, output bit er, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    logic [63:0] rd;
    logic [63:0] heldData;
    bit          er;
    int          lat;

    initial begin
        vecs[0]  = '{"wr_100",     1'b1, 64'h100, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[1]  = '{"rd_100",     1'b0, 64'h100, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        vecs[2]  = '{"wr_108",     1'b1, 64'h108, 64'h00000000000000A5, 64'h0, 1'b0};
        vecs[3]  = '{"rd_101",     1'b0, 64'h101, 64'h0, 64'hA50123456789ABCD, 1'b0};
        vecs[4]  = '{"wr_203",     1'b1, 64'h203, 64'h00000000000000FF, 64'h0, 1'b0};
        vecs[5]  = '{"rd_203",     1'b0, 64'h203, 64'h0, 64'h00000000000000FF, 1'b0};
        vecs[6]  = '{"wr_0",       1'b1, 64'h0,   64'h0706050403020100, 64'h0, 1'b0};
        vecs[7]  = '{"wr_1016",    1'b1, 64'd1016, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0};
        vecs[8]  = '{"rd_1016",    1'b0, 64'd1016, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[9]  = '{"rd_1017",    1'b0, 64'd1017, 64'h0, 64'h0, 1'b1};
        vecs[10] = '{"wr_wrap",    1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555555555555555, 64'h0, 1'b1};
        vecs[11] = '{"rd_1016_b",  1'b0, 64'd1016, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[12] = '{"rd_0",       1'b0, 64'h0,   64'h0, 64'h0706050403020100, 1'b0};
        vecs[13] = '{"rd_100_b",   1'b0, 64'h100, 64'h0, 64'h0123456789ABCDEF, 1'b0};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        check("rst_rsp_error", 64'(rsp_error), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'h1);

        // Table-driven transactions
        for (int i = 0; i < 14; i++) begin
            doReq(vecs[i].write, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].expRdata);
            check({vecs[i].name, "_error"}, 64'(er), 64'(vecs[i].expErr));
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(c_LATENCY));
        end

        // Backpressure: response held while a competing request is ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h100;
        @(posedge clk);
        #1;
        req_write = 1'b1;
        req_wdata = 64'hBADBADBADBADBAD0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(c_LATENCY));
        heldData = 64'h0123456789ABCDEF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            check("bp_rsp_rdata", rsp_rdata, heldData);
            check("bp_req_ready", 64'(req_ready), 64'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_release_valid", 64'(rsp_valid), 64'h0);
        check("bp_release_ready", 64'(req_ready), 64'h1);
        check("bp_release_rdata", rsp_rdata, 64'h0);
        doReq(1'b0, 64'h100, 64'h0, rd, er, lat);
        check("bp_ignored_write", rd, 64'h0123456789ABCDEF);

        // Reset while a write sits in BUSY must not commit it
        doReq(1'b1, 64'h300, 64'h11, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h300;
        req_wdata = 64'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("midbusy_rst_ready", 64'(req_ready), 64'h0);
        check("midbusy_rst_valid", 64'(rsp_valid), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        doReq(1'b0, 64'h300, 64'h0, rd, er, lat);
        check("midbusy_rd_300", rd, 64'h11);
        check("midbusy_rd_err", 64'(er), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

    // Absolute watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_y86_data_memory
`default_nettype wire
